// File: rtl/cmd_pulse_pkg.sv
// Shared types and constants for the command pulse controller.
// The legality check is evaluated at elaboration by the top level.
package cmd_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_BUSY  = 2'd2
    } chan_state_e;

    localparam int WDOG_W = 24;
    localparam int PCNT_W = 8;

    function automatic bit params_ok(input int n_ch, input int sync_stages,
                                     input int pulse_len, input int wait_done,
                                     input int timeout);
        return (n_ch >= 1) &&
               (sync_stages >= 1) && (sync_stages <= 3) &&
               (pulse_len >= 1) && (pulse_len <= 255) &&
               (wait_done >= 0) && (wait_done <= 1) &&
               (timeout >= 0) && (timeout <= (1 << WDOG_W) - 1);
    endfunction

endpackage

// File: rtl/cmd_pulse_chan.sv
// One command channel: enable synchroniser, rising-edge detect, IDLE/PULSE/BUSY
// sequencer with pulse counter, done latch, watchdog and sticky status flags.
module cmd_pulse_chan
    import cmd_pulse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int WAIT_DONE   = 1,
    parameter int TIMEOUT     = 65535
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic en_i,
    input  logic done_i,
    input  logic clr_i,
    output logic pulse_o,
    output logic busy_o,
    output logic overrun_o,
    output logic timeout_o
);

    localparam logic [PCNT_W-1:0] PCNT_INIT = PCNT_W'(PULSE_LEN - 1);
    localparam bit                WDOG_EN   = (TIMEOUT != 0);
    // Expiry is detected one count early so the exit lands exactly TIMEOUT edges after BUSY entry.
    localparam logic [WDOG_W-1:0] WDOG_LIM  = WDOG_EN ? WDOG_W'(TIMEOUT - 1) : '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   en_p_q;
    logic                   rise;
    chan_state_e            state_q;
    logic [PCNT_W-1:0]      pcnt_q;
    logic [WDOG_W-1:0]      wdog_q;
    logic                   dlatch_q;

    assign rise = sync_q[SYNC_STAGES-1] & ~en_p_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync_q    <= '0;
            en_p_q    <= 1'b0;
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            wdog_q    <= '0;
            dlatch_q  <= 1'b0;
            pulse_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            sync_q[0] <= en_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            en_p_q <= sync_q[SYNC_STAGES-1];

            // Later assignments below take priority, so a set beats a same-cycle clear.
            if (clr_i) begin
                overrun_o <= 1'b0;
                timeout_o <= 1'b0;
            end
            if (rise && state_q != ST_IDLE) overrun_o <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_PULSE;
                        pcnt_q  <= PCNT_INIT;
                        pulse_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (done_i) dlatch_q <= 1'b1;
                    if (pcnt_q == '0) begin
                        pulse_o <= 1'b0;
                        if (WAIT_DONE != 0 && !(dlatch_q || done_i)) begin
                            state_q <= ST_BUSY;
                            wdog_q  <= '0;
                        end else begin
                            state_q  <= ST_IDLE;
                            busy_o   <= 1'b0;
                            dlatch_q <= 1'b0;
                        end
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (done_i) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else if (WDOG_EN && wdog_q == WDOG_LIM) begin
                        state_q   <= ST_IDLE;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else if (wdog_q != '1) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    pulse_o  <= 1'b0;
                    busy_o   <= 1'b0;
                    dlatch_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cmd_pulse_ctrl.sv
// N_CH independent register-enable to start-pulse channels with busy/done
// handshake, watchdog and sticky overrun/timeout status.
module cmd_pulse_ctrl
    import cmd_pulse_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int WAIT_DONE   = 1,
    parameter int TIMEOUT     = 65535
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [N_CH-1:0] en_i,
    input  logic [N_CH-1:0] done_i,
    input  logic [N_CH-1:0] clr_i,
    output logic [N_CH-1:0] pulse_o,
    output logic [N_CH-1:0] busy_o,
    output logic [N_CH-1:0] overrun_o,
    output logic [N_CH-1:0] timeout_o
);

    localparam bit PARAMS_OK = params_ok(N_CH, SYNC_STAGES, PULSE_LEN, WAIT_DONE, TIMEOUT);

    if (!PARAMS_OK) begin : g_param_err
        $error("cmd_pulse_ctrl: illegal parameter set");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cmd_pulse_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .PULSE_LEN  (PULSE_LEN),
            .WAIT_DONE  (WAIT_DONE),
            .TIMEOUT    (TIMEOUT)
        ) u_chan (
            .clk_i    (clk_i),
            .resetn_i (resetn_i),
            .en_i     (en_i[g]),
            .done_i   (done_i[g]),
            .clr_i    (clr_i[g]),
            .pulse_o  (pulse_o[g]),
            .busy_o   (busy_o[g]),
            .overrun_o(overrun_o[g]),
            .timeout_o(timeout_o[g])
        );
    end

endmodule

// File: tb/tb_cmd_pulse_ctrl.sv
// Scoreboard bench for cmd_pulse_ctrl: two configurations share one stimulus stream;
// a timeline model predicts per-edge outputs that a monitor compares after each edge.
module tb_cmd_pulse_ctrl;

    localparam int N_CH = 4;
    localparam int SS   = 2;
    localparam int PLEN  [2] = '{4, 1};
    localparam int WDONE [2] = '{1, 0};
    localparam int TMO   [2] = '{100, 0};

    typedef struct packed {
        logic [N_CH-1:0] p;
        logic [N_CH-1:0] b;
        logic [N_CH-1:0] o;
        logic [N_CH-1:0] t;
    } obs_t;

    typedef struct packed {
        obs_t i0;
        obs_t i1;
    } pair_t;

    typedef struct packed {
        bit act;
        bit dseen;
        int pstart;
        int bstart;
        bit ovr;
        bit tmo;
    } chm_t;

    logic            clk_i = 1'b0;
    logic            resetn_i;
    logic [N_CH-1:0] en_i, done_i, clr_i;
    logic [N_CH-1:0] pulse0, busy0, ovr0, tmo0;
    logic [N_CH-1:0] pulse1, busy1, ovr1, tmo1;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    running  = 0;
    pair_t sb_q [$];

    logic [N_CH-1:0] en_hist [int];
    chm_t            m [2][N_CH];
    int              t;
    logic [N_CH-1:0] en_cur;

    always #5 clk_i = ~clk_i;

    cmd_pulse_ctrl #(
        .N_CH(N_CH), .SYNC_STAGES(SS), .PULSE_LEN(4), .WAIT_DONE(1), .TIMEOUT(100)
    ) u_dut0 (
        .clk_i(clk_i), .resetn_i(resetn_i), .en_i(en_i), .done_i(done_i), .clr_i(clr_i),
        .pulse_o(pulse0), .busy_o(busy0), .overrun_o(ovr0), .timeout_o(tmo0)
    );

    cmd_pulse_ctrl #(
        .N_CH(N_CH), .SYNC_STAGES(SS), .PULSE_LEN(1), .WAIT_DONE(0), .TIMEOUT(0)
    ) u_dut1 (
        .clk_i(clk_i), .resetn_i(resetn_i), .en_i(en_i), .done_i(done_i), .clr_i(clr_i),
        .pulse_o(pulse1), .busy_o(busy1), .overrun_o(ovr1), .timeout_o(tmo1)
    );

    function automatic void check(input string name, input logic [N_CH-1:0] act,
                                  input logic [N_CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, t, act, exp);
        end
    endfunction

    function automatic bit en_bit(input int idx, input int c);
        if (idx < 0 || !en_hist.exists(idx)) return 1'b0;
        return en_hist[idx][c];
    endfunction

    function automatic void model_reset();
        en_hist.delete();
        t = 0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N_CH; c++) m[k][c] = '0;
    endfunction

    // Outputs after edge t, reasoned as pulse/busy windows on the edge timeline.
    function automatic pair_t model_step(input logic [N_CH-1:0] en,
                                         input logic [N_CH-1:0] done,
                                         input logic [N_CH-1:0] clr);
        obs_t  e [2];
        pair_t r;
        en_hist[t] = en;
        for (int k = 0; k < 2; k++) begin
            e[k] = '0;
            for (int c = 0; c < N_CH; c++) begin
                chm_t s;
                bit   rs, oset, tset;
                int   pend;
                s    = m[k][c];
                rs   = en_bit(t - SS, c) && !en_bit(t - SS - 1, c);
                oset = rs && s.act;
                tset = 0;
                if (s.act) begin
                    pend = s.pstart + PLEN[k];
                    if (t <= pend) begin
                        if (done[c]) s.dseen = 1;
                        if (t == pend) begin
                            if (WDONE[k] == 0 || s.dseen) s.act = 0;
                            else s.bstart = t;
                        end
                    end else if (done[c]) begin
                        s.act = 0;
                    end else if (TMO[k] != 0 && t - s.bstart == TMO[k]) begin
                        s.act = 0;
                        tset  = 1;
                    end
                end else if (rs) begin
                    s.act    = 1;
                    s.pstart = t;
                    s.dseen  = 0;
                end
                if (clr[c]) begin
                    s.ovr = 0;
                    s.tmo = 0;
                end
                if (oset) s.ovr = 1;
                if (tset) s.tmo = 1;
                m[k][c]   = s;
                e[k].p[c] = s.act && (t < s.pstart + PLEN[k]);
                e[k].b[c] = s.act;
                e[k].o[c] = s.ovr;
                e[k].t[c] = s.tmo;
            end
        end
        t++;
        r.i0 = e[0];
        r.i1 = e[1];
        return r;
    endfunction

    task automatic drive(input logic [N_CH-1:0] en, input logic [N_CH-1:0] done,
                         input logic [N_CH-1:0] clr);
        en_i   = en;
        done_i = done;
        clr_i  = clr;
        sb_q.push_back(model_step(en, done, clr));
    endtask

    task automatic cyc(input logic [N_CH-1:0] done, input logic [N_CH-1:0] clr);
        @(negedge clk_i);
        drive(en_cur, done, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dut0.pulse_o"}, pulse0, '0);
        check({tag, " dut0.busy_o"},  busy0,  '0);
        check({tag, " dut0.overrun_o"}, ovr0, '0);
        check({tag, " dut0.timeout_o"}, tmo0, '0);
        check({tag, " dut1.pulse_o"}, pulse1, '0);
        check({tag, " dut1.busy_o"},  busy1,  '0);
        check({tag, " dut1.overrun_o"}, ovr1, '0);
        check({tag, " dut1.timeout_o"}, tmo1, '0);
    endtask

    // Reset is asserted mid-cycle so outputs must fall without a clock edge.
    task automatic do_reset(input int hold);
        @(negedge clk_i);
        resetn_i = 1'b0;
        done_i   = '0;
        clr_i    = '0;
        #1;
        check_all_zero("async_reset");
        repeat (hold) @(negedge clk_i);
        resetn_i = 1'b1;
        model_reset();
        drive(en_cur, '0, '0);
    endtask

    initial begin : monitor
        pair_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (running && resetn_i) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty at edge %0d: got no entry expected one", t);
                end else begin
                    e = sb_q.pop_front();
                    check("dut0.pulse_o",   pulse0, e.i0.p);
                    check("dut0.busy_o",    busy0,  e.i0.b);
                    check("dut0.overrun_o", ovr0,   e.i0.o);
                    check("dut0.timeout_o", tmo0,   e.i0.t);
                    check("dut1.pulse_o",   pulse1, e.i1.p);
                    check("dut1.busy_o",    busy1,  e.i1.b);
                    check("dut1.overrun_o", ovr1,   e.i1.o);
                    check("dut1.timeout_o", tmo1,   e.i1.t);
                end
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL sim_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin : stim
        en_cur   = '0;
        en_i     = '0;
        done_i   = '0;
        clr_i    = '0;
        resetn_i = 1'b1;
        model_reset();
        #1 resetn_i = 1'b0;
        #1;
        check_all_zero("reset_state");
        running = 1;
        repeat (2) @(negedge clk_i);
        resetn_i = 1'b1;
        drive(en_cur, '0, '0);
        idle(5);

        // Single rise on ch0, level then held: one pulse only.
        en_cur[0] = 1'b1;
        idle(12);
        en_cur[0] = 1'b0;
        idle(3);
        cyc(4'b0001, '0);

        // ch1 rise, done 20+ cycles later.
        en_cur[1] = 1'b1;
        idle(25);
        cyc(4'b0010, '0);
        idle(3);
        en_cur[1] = 1'b0;

        // ch2 overrun while busy, then normal pulse, flag kept until clear.
        en_cur[2] = 1'b1;
        idle(10);
        en_cur[2] = 1'b0;
        idle(2);
        en_cur[2] = 1'b1;
        idle(3);
        cyc(4'b0100, '0);
        idle(2);
        en_cur[2] = 1'b0;
        idle(2);
        en_cur[2] = 1'b1;
        idle(8);
        cyc('0, 4'b0100);
        idle(2);
        cyc(4'b0100, '0);
        en_cur[2] = 1'b0;
        idle(3);

        // ch1 watchdog expiry, clear, then clear coincident with expiry.
        en_cur[1] = 1'b1;
        for (int k = 0; k < 110; k++) cyc('0, (k == 108) ? 4'b0010 : 4'b0000);
        en_cur[1] = 1'b0;
        idle(3);
        en_cur[1] = 1'b1;
        for (int k = 0; k < 110; k++) cyc('0, (k == 106) ? 4'b0010 : 4'b0000);
        en_cur[1] = 1'b0;
        idle(3);
        cyc('0, 4'b0010);
        idle(2);

        // All channels rise together; ch3 sees done during its pulse.
        cyc(4'hF, '0);
        en_cur = '0;
        idle(4);
        en_cur = 4'hF;
        for (int k = 0; k < 10; k++) cyc((k == 3) ? 4'b1000 : 4'b0000, '0);
        cyc(4'h7, '0);
        idle(2);

        // Reset during a pulse with en_i held high: exactly one re-issued pulse.
        en_cur = '0;
        idle(3);
        en_cur[0] = 1'b1;
        for (int k = 0; k < 4; k++) cyc('0, '0);
        do_reset(3);
        idle(12);
        cyc(4'hF, '0);
        en_cur = '0;
        idle(3);

        // Randomised traffic; per-channel done rates spread so some channels time out.
        for (int i = 0; i < 1500; i++) begin
            logic [N_CH-1:0] d, c;
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(7, 0) == 0) en_cur[ch] = ~en_cur[ch];
                d[ch] = ($urandom_range((4 << (2 * ch)) - 1, 0) == 0);
                c[ch] = ($urandom_range(31, 0) == 0);
            end
            cyc(d, c);
        end

        @(posedge clk_i);
        #2;
        running = 0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_pulse_ctrl.md
Name: cmd_pulse_ctrl

Overview:
- Parametrised successor of the register-enable-to-pulse converter: N_CH independent command channels turn register-driven enable levels into fixed-length start pulses for memory/FIFO engines (DDR3 write/read, DIGIFIFO/MEMFIFO transfers).
- Adds:
  - input synchronisation
  - programmable pulse length
  - busy/done handshake with the downstream engine
  - watchdog timeout
  - sticky overrun/timeout status readable by the register module.

Parameters:
- N_CH, 4, number of command channels
- SYNC_STAGES, 2, synchroniser flops on each en_i bit (legal 1..3)
- PULSE_LEN, 1, pulse_o high time in clk_i cycles (legal 1..255)
- WAIT_DONE, 1, 1 = hold channel busy until done_i or timeout; 0 = return to IDLE after pulse
- TIMEOUT, 65535, BUSY watchdog limit in cycles; 0 disables watchdog (legal 0..2^24-1)

Ports:
- clk_i  in  1  system clock
- resetn_i  in  1  asynchronous active-low reset
- en_i  in  N_CH  enable levels from register module, may be asynchronous
- done_i  in  N_CH  per-channel completion strobe from engine, synchronous, ≥1 cycle
- clr_i  in  N_CH  per-channel clear of sticky flags, synchronous pulse
- pulse_o  out  N_CH  start pulse to engine
- busy_o  out  N_CH  channel not IDLE
- overrun_o  out  N_CH  sticky: rising edge arrived while channel busy
- timeout_o  out  N_CH  sticky: BUSY watchdog expired

Behaviour:
- Reset is asynchronous active-low on resetn_i, single clock clk_i.
- While resetn_i=0, every flop is 0:
  - synchroniser, edge-history flop, FSM=IDLE, counters, done latch, all outputs 0.
- Edge detect:
  - en_i passes through SYNC_STAGES flops giving s.
  - One history flop holds p.
  - rise = s & ~p.
  - Only rising edges act. Falling edges and held levels do nothing.
- Latency: en_i sampled high at clk edge 0 → pulse_o high after edge SYNC_STAGES, for exactly PULSE_LEN cycles. All outputs are registered.
- Per-channel FSM states: IDLE, PULSE, BUSY.
  - IDLE:
    - rise → PULSE, load pulse counter with PULSE_LEN-1.
  - PULSE:
    - pulse_o=1; counter decrements each cycle.
    - When counter=0: WAIT_DONE=1 → BUSY (or straight to IDLE if the done latch is set); WAIT_DONE=0 → IDLE.
  - BUSY:
    - done_i=1 → IDLE next edge.
    - Otherwise the watchdog increments. When it reaches TIMEOUT (TIMEOUT≠0): → IDLE and set timeout_o.
    - done_i and expiry in the same cycle → IDLE, timeout_o not set.
- done_i during PULSE is latched (done latch); the latch clears on entry to IDLE. done_i in IDLE is ignored.
- busy_o = (state≠IDLE), registered with state.
- Overrun: rise while state≠IDLE sets overrun_o. The edge is dropped, never queued.
- Clear: clr_i clears overrun_o and timeout_o on the next edge. Set and clear in the same cycle → set wins.
- The watchdog counter is 24 bits wide, saturates, and resets to 0 on BUSY entry.
- Channels are fully independent. Simultaneous rises on several channels each produce their own pulse in the same cycle.
- Reset mid-operation:
  - FSM aborts immediately, pulse_o drops asynchronously, flags clear.
  - If en_i is still high when resetn_i deasserts, the synchroniser fills with 1 while p=0, giving exactly one pulse at the normal latency. Firmware relies on this to re-issue commands.
- en_i glitches shorter than one clk_i period may be missed. This is permitted.

Decomposition:
- Package cmd_pulse_pkg:
  - FSM state encoding (IDLE=2'd0, PULSE=2'd1, BUSY=2'd2)
  - WDOG_W=24 and pulse counter width constant 8
  - parameter legality check function
- Sub-module cmd_pulse_chan: one channel containing synchroniser, edge detect, FSM, counters and sticky flags. It is instantiated N_CH times by a generate loop in cmd_pulse_ctrl.

Test Plan:
- SYNC_STAGES=2, PULSE_LEN=1, WAIT_DONE=0: en_i[0] 0→1 sampled at edge 10 → pulse_o[0] high only between edges 12 and 13; busy_o[0] same window; en_i held high thereafter → no further pulses.
- PULSE_LEN=4, WAIT_DONE=1: rise on ch1 → pulse_o[1] high 4 cycles, busy_o[1] stays high; done_i[1] pulsed 20 cycles later → busy_o[1] low one edge after done.
- TIMEOUT=100, done_i never asserted → busy_o drops and timeout_o sets 100 cycles after BUSY entry; clr_i pulse → timeout_o=0 next edge; clr_i coincident with a new expiry → timeout_o stays 1.
- While ch2 BUSY, toggle en_i[2] 0→1 → no pulse, overrun_o[2]=1; after done, next rise pulses normally; overrun_o stays set until clr_i[2].
- All four en_i rise in the same cycle → four simultaneous pulse_o bits; done_i[3] asserted during PULSE → ch3 returns to IDLE at end of pulse without entering BUSY.
- resetn_i asserted mid-PULSE with en_i high → pulse_o falls without waiting for a clock; after release → exactly one pulse SYNC_STAGES edges later, flags 0.
